// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush control for F/D/E/M/W,
// Execute-stage operand forwarding, MDU/memory wait sequencing and stall/flush statistics.
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MDU_MAXW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wrE,
  input  logic             reg_wrM,
  input  logic             reg_wrW,
  input  logic             rd_enE,
  input  logic             rd_enM,
  input  logic             wr_enM,
  input  logic             br_takenE,
  input  logic             mdu_startE,
  input  logic             mdu_done,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, MDU = 2'd1, MEM = 2'd2} state_e;
  localparam int WC_W = $clog2(MDU_MAXW + 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic memop, load_use, tmo_hit, br_flush;

  assign memop    = (rd_enM | wr_enM) & ~dmem_ready;
  assign load_use = rd_enE & reg_wrE & (rd_E != 5'd0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
  assign tmo_hit  = (wcnt_q >= WC_W'(MDU_MAXW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      if (stall_F && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (br_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN: begin
        if (memop) begin
          state_d = MEM;
        end else if (mdu_startE && !mdu_done) begin
          state_d = MDU;
          wcnt_d  = WC_W'(1);
        end
      end
      MEM: if (dmem_ready) state_d = RUN;
      MDU: begin
        if (mdu_done) begin
          state_d = RUN;
        end else if (tmo_hit) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Branch flush / load-use bubble apply only in cycles where nothing holds E.
  always_comb begin
    logic bl_en, mdu_hold;
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_M  = 1'b0;
    flush_W  = 1'b0;
    br_flush = 1'b0;
    bl_en    = 1'b0;
    mdu_hold = 1'b0;
    case (state_q)
      RUN: begin
        if (memop) begin
          {stall_F, stall_D, stall_E, stall_M, flush_W} = 5'b11111;
        end else if (mdu_startE && !mdu_done) begin
          {stall_F, stall_D, stall_E, flush_M} = 4'b1111;
        end else begin
          bl_en = 1'b1;
        end
      end
      MEM: begin
        if (!dmem_ready) {stall_F, stall_D, stall_E, stall_M, flush_W} = 5'b11111;
        else bl_en = 1'b1;
      end
      MDU: begin
        mdu_hold = !mdu_done && !tmo_hit;
        if (mdu_hold) {stall_F, stall_D, stall_E, flush_M} = 4'b1111;
        if (memop) {stall_F, stall_D, stall_E, stall_M, flush_W} = 5'b11111;
        bl_en = !mdu_hold && !memop;
      end
      default: ;
    endcase
    if (bl_en) begin
      if (br_takenE) begin
        {flush_D, flush_E} = 2'b11;
        br_flush = 1'b1;
      end else if (load_use) begin
        {stall_F, stall_D, flush_E} = 3'b111;
      end
    end
    if (rst) begin
      {stall_F, stall_D, stall_E, stall_M} = 4'b0000;
      {flush_D, flush_E, flush_M, flush_W} = 4'b0000;
      br_flush = 1'b0;
    end
  end

  // A load still in M has no result yet, so only non-load M writes forward.
  always_comb begin
    fwd_A = 2'b00;
    fwd_B = 2'b00;
    if (reg_wrM && !rd_enM && (rd_M != 5'd0) && (rd_M == rs1_E)) fwd_A = 2'b01;
    else if (reg_wrW && (rd_W != 5'd0) && (rd_W == rs1_E))       fwd_A = 2'b10;
    if (reg_wrM && !rd_enM && (rd_M != 5'd0) && (rd_M == rs2_E)) fwd_B = 2'b01;
    else if (reg_wrW && (rd_W != 5'd0) && (rd_W == rs2_E))       fwd_B = 2'b10;
  end

  assign state        = state_q;
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule
